// File: rtl/core_hazard_ctrl_if.sv
// Hazard-unit bundle: decode operands and per-pipe-register status in,
// pipeline enables, forward selects and performance counters out.
interface core_hazard_ctrl_if #(
  parameter int NSTAGE = 4,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16,
  parameter int FSW    = $clog2(NSTAGE)
);
  logic [REG_AW-1:0]        id_rs1, id_rs2;
  logic                     id_rs1_used, id_rs2_used;
  logic [NSTAGE*REG_AW-1:0] st_rd;
  logic [NSTAGE-1:0]        st_we, st_load;
  logic                     redirect, imem_busy, imem_done, dmem_busy, cnt_clr;
  logic [NSTAGE-1:0]        pipe_en, pipe_flush;
  logic                     pc_write;
  logic [FSW-1:0]           fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0]         stall_cnt, flush_cnt;

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, st_rd, st_we, st_load,
           redirect, imem_busy, imem_done, dmem_busy, cnt_clr,
    output pipe_en, pipe_flush, pc_write, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
  );
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, st_rd, st_we, st_load,
           redirect, imem_busy, imem_done, dmem_busy, cnt_clr,
    input  pipe_en, pipe_flush, pc_write, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/core_hazard_ctrl.sv
// RV32I pipeline hazard control: forwarding/load-use detection, redirect squash FSM,
// memory-busy freeze and saturating stall/flush counters.
module core_hazard_ctrl #(
  parameter int NSTAGE         = 4,
  parameter int REG_AW         = 5,
  parameter bit FWD_EN         = 1'b1,
  parameter int LOAD_FWD_STAGE = 3,
  parameter int REDIRECT_STAGE = 1,
  parameter int DMEM_STAGE     = 2,
  parameter int CNT_W          = 16,
  parameter int FSW            = $clog2(NSTAGE)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  core_hazard_ctrl_if.slave  hz
);
  typedef enum logic {RUN, SQUASH} state_t;
  typedef struct packed {
    logic           hit;
    logic [FSW-1:0] k;
    logic           ld;
  } match_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic flush_inc;

  // Scan oldest to youngest so the smallest matching index wins.
  function automatic match_t youngest(input logic [REG_AW-1:0] rs, input logic used,
                                      input logic [NSTAGE*REG_AW-1:0] rd,
                                      input logic [NSTAGE-1:0] we, input logic [NSTAGE-1:0] ld);
    match_t m;
    m = '0;
    for (int k = NSTAGE-1; k >= 1; k--) begin
      if (used && rs != '0 && we[k] && rd[k*REG_AW +: REG_AW] == rs) begin
        m.hit = 1'b1;
        m.k   = FSW'(k);
        m.ld  = ld[k];
      end
    end
    return m;
  endfunction

  match_t m1, m2;
  logic   haz1, haz2, hazard;

  always_comb begin
    m1 = youngest(hz.id_rs1, hz.id_rs1_used, hz.st_rd, hz.st_we, hz.st_load);
    m2 = youngest(hz.id_rs2, hz.id_rs2_used, hz.st_rd, hz.st_we, hz.st_load);
    if (FWD_EN) begin
      haz1 = m1.hit && m1.ld && (int'(m1.k) < LOAD_FWD_STAGE);
      haz2 = m2.hit && m2.ld && (int'(m2.k) < LOAD_FWD_STAGE);
    end else begin
      haz1 = m1.hit;
      haz2 = m2.hit;
    end
    hazard = haz1 || haz2;
  end

  always_comb begin
    hz.pipe_en    = '1;
    hz.pipe_flush = '0;
    hz.pc_write   = 1'b1;
    hz.fwd_sel1   = (FWD_EN && m1.hit && !haz1) ? m1.k : '0;
    hz.fwd_sel2   = (FWD_EN && m2.hit && !haz2) ? m2.k : '0;
    state_d       = state_q;
    flush_inc     = 1'b0;
    if (rst_i) begin
      hz.pipe_en    = '0;
      hz.pipe_flush = '1;
      hz.pc_write   = 1'b0;
      hz.fwd_sel1   = '0;
      hz.fwd_sel2   = '0;
      state_d       = RUN;
    end else if (hz.dmem_busy) begin
      // Frozen redirect stays on the bus and is taken once the freeze lifts.
      for (int k = 0; k < NSTAGE; k++)
        if (k <= DMEM_STAGE) hz.pipe_en[k] = 1'b0;
      hz.pc_write = 1'b0;
      if (state_q == SQUASH && hz.imem_done) begin
        hz.pipe_flush[0] = 1'b1;
        state_d          = RUN;
      end
    end else if (hz.redirect) begin
      for (int k = 0; k < NSTAGE; k++)
        if (k <= REDIRECT_STAGE) hz.pipe_flush[k] = 1'b1;
      hz.pc_write = 1'b1;
      flush_inc   = 1'b1;
      if (state_q == SQUASH || hz.imem_busy) state_d = SQUASH;
      else                                   state_d = RUN;
    end else if (state_q == SQUASH) begin
      hz.pc_write      = 1'b0;
      hz.pipe_en[0]    = 1'b0;
      hz.pipe_flush[0] = 1'b1;
      if (hz.imem_done) state_d = RUN;
    end else if (hz.imem_busy || hazard) begin
      hz.pc_write      = 1'b0;
      hz.pipe_en[0]    = 1'b0;
      hz.pipe_flush[1] = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!hz.pc_write && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_inc && flush_cnt_q != '1)    flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed bench: default-parameter instance plus a FWD_EN=0 / 4-bit-counter instance
// sharing the same stimulus.
module tb_core_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  core_hazard_ctrl_if #(.NSTAGE(4), .REG_AW(5), .CNT_W(16)) h ();
  core_hazard_ctrl_if #(.NSTAGE(4), .REG_AW(5), .CNT_W(4))  h0 ();

  core_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) dut  (.clk_i(clk), .rst_i(rst), .hz(h.slave));
  core_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(4))  dut0 (.clk_i(clk), .rst_i(rst), .hz(h0.slave));

  assign h0.id_rs1      = h.id_rs1;
  assign h0.id_rs2      = h.id_rs2;
  assign h0.id_rs1_used = h.id_rs1_used;
  assign h0.id_rs2_used = h.id_rs2_used;
  assign h0.st_rd       = h.st_rd;
  assign h0.st_we       = h.st_we;
  assign h0.st_load     = h.st_load;
  assign h0.redirect    = h.redirect;
  assign h0.imem_busy   = h.imem_busy;
  assign h0.imem_done   = h.imem_done;
  assign h0.dmem_busy   = h.dmem_busy;
  assign h0.cnt_clr     = h.cnt_clr;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h.id_rs1 = '0; h.id_rs2 = '0; h.id_rs1_used = 1'b0; h.id_rs2_used = 1'b0;
    h.st_rd = '0; h.st_we = '0; h.st_load = '0;
    h.redirect = 1'b0; h.imem_busy = 1'b0; h.imem_done = 1'b0;
    h.dmem_busy = 1'b0; h.cnt_clr = 1'b0;
  endtask

  initial begin
    idle();
    cyc(2);
    chk("rst_pipe_en",    32'(h.pipe_en),    32'h0);
    chk("rst_pipe_flush", 32'(h.pipe_flush), 32'hF);
    chk("rst_pc_write",   32'(h.pc_write),   32'h0);
    chk("rst_stall_cnt",  32'(h.stall_cnt),  32'h0);
    rst = 1'b0;
    #1;
    chk("idle_pc_write", 32'(h.pc_write), 32'h1);
    chk("idle_pipe_en",  32'(h.pipe_en),  32'hF);

    // Load-use: load to x5 in ID/EX, then EX/MEM, then MEM/WB
    h.id_rs1 = 5'd5; h.id_rs1_used = 1'b1;
    h.st_we = 4'b0010; h.st_load = 4'b0010; h.st_rd[5 +: 5] = 5'd5;
    #1;
    chk("lu_pc_write",   32'(h.pc_write),   32'h0);
    chk("lu_pipe_en",    32'(h.pipe_en),    32'hE);
    chk("lu_pipe_flush", 32'(h.pipe_flush), 32'h2);
    cyc();
    chk("lu_stall_cnt1", 32'(h.stall_cnt), 32'h1);
    h.st_rd = '0; h.st_we = 4'b0100; h.st_load = 4'b0100; h.st_rd[10 +: 5] = 5'd5;
    #1;
    chk("lu_stage2_stall", 32'(h.pc_write), 32'h0);
    cyc();
    h.st_rd = '0; h.st_we = 4'b1000; h.st_load = 4'b1000; h.st_rd[15 +: 5] = 5'd5;
    #1;
    chk("lu_fwd_sel1",  32'(h.fwd_sel1), 32'h3);
    chk("lu_no_stall",  32'(h.pc_write), 32'h1);
    cyc();
    chk("lu_stall_cnt", 32'(h.stall_cnt), 32'h2);

    // Forwarding priority: x7 written in stages 1 and 2
    idle();
    h.id_rs2 = 5'd7; h.id_rs2_used = 1'b1;
    h.st_we = 4'b0110; h.st_rd[5 +: 5] = 5'd7; h.st_rd[10 +: 5] = 5'd7;
    #1;
    chk("fp_fwd_sel2", 32'(h.fwd_sel2), 32'h1);
    chk("fp_pc_write", 32'(h.pc_write), 32'h1);
    h.id_rs2 = 5'd0;
    #1;
    chk("fp_x0_fwd_sel2", 32'(h.fwd_sel2), 32'h0);
    h.id_rs2 = 5'd7; h.id_rs2_used = 1'b0;
    #1;
    chk("fp_unused_fwd", 32'(h.fwd_sel2), 32'h0);

    // x9 in MEM/WB: forwarded by default instance, stall when forwarding disabled
    idle();
    h.id_rs1 = 5'd9; h.id_rs1_used = 1'b1;
    h.st_we = 4'b1000; h.st_rd[15 +: 5] = 5'd9;
    #1;
    chk("nf_pc_write", 32'(h0.pc_write), 32'h0);
    chk("nf_fwd_sel1", 32'(h0.fwd_sel1), 32'h0);
    chk("nf_flush",    32'(h0.pipe_flush), 32'h2);
    chk("fw_fwd_sel1", 32'(h.fwd_sel1), 32'h3);
    chk("fw_pc_write", 32'(h.pc_write), 32'h1);
    cyc();

    // Redirect with fetch in flight
    idle();
    h.redirect = 1'b1; h.imem_busy = 1'b1;
    #1;
    chk("rd_flush",    32'(h.pipe_flush), 32'h3);
    chk("rd_pc_write", 32'(h.pc_write),   32'h1);
    cyc();
    h.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sq_pc_write", 32'(h.pc_write),   32'h0);
      chk("sq_flush",    32'(h.pipe_flush), 32'h1);
      cyc();
    end
    h.imem_done = 1'b1;
    #1;
    chk("sq_done_flush", 32'(h.pipe_flush), 32'h1);
    cyc();
    h.imem_done = 1'b0; h.imem_busy = 1'b0;
    #1;
    chk("sq_back_run", 32'(h.pc_write),  32'h1);
    chk("sq_flush_cnt", 32'(h.flush_cnt), 32'h1);

    // DMEM freeze over a pending redirect
    h.dmem_busy = 1'b1; h.redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dm_pipe_en", 32'(h.pipe_en),    32'h8);
      chk("dm_flush",   32'(h.pipe_flush), 32'h0);
      cyc();
    end
    chk("dm_flush_cnt_hold", 32'(h.flush_cnt), 32'h1);
    h.dmem_busy = 1'b0;
    #1;
    chk("dm_release_flush", 32'(h.pipe_flush), 32'h3);
    cyc();
    h.redirect = 1'b0;
    chk("dm_flush_cnt", 32'(h.flush_cnt), 32'h2);

    // Reset in the middle of a squash
    h.redirect = 1'b1; h.imem_busy = 1'b1;
    cyc();
    h.redirect = 1'b0;
    #1;
    chk("rs_in_squash", 32'(h.pc_write), 32'h0);
    rst = 1'b1;
    #1;
    chk("rs_pipe_en",  32'(h.pipe_en),    32'h0);
    chk("rs_flush",    32'(h.pipe_flush), 32'hF);
    chk("rs_fwd_sel1", 32'(h.fwd_sel1),   32'h0);
    cyc(2);
    chk("rs_flush_cnt", 32'(h.flush_cnt), 32'h0);
    rst = 1'b0; h.imem_busy = 1'b0;
    #1;
    chk("rs_state_run", 32'(h.pc_write), 32'h1);

    // Counter clear concurrent with a stall, then saturation on the 4-bit instance
    h.id_rs1 = 5'd9; h.id_rs1_used = 1'b1;
    h.st_we = 4'b0010; h.st_load = 4'b0010; h.st_rd = '0; h.st_rd[5 +: 5] = 5'd9;
    cyc();
    chk("cc_pre_clr", 32'(h.stall_cnt), 32'h1);
    h.cnt_clr = 1'b1;
    cyc();
    chk("cc_clr_stall", 32'(h.stall_cnt), 32'h0);
    h.cnt_clr = 1'b0;
    cyc(15);
    chk("sat_reach", 32'(h0.stall_cnt), 32'hF);
    cyc(5);
    chk("sat_hold",  32'(h0.stall_cnt), 32'hF);
    chk("sat_big_cnt", 32'(h.stall_cnt), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_hazard_ctrl.md
# core_hazard_ctrl

Parametrised hazard control unit for the pipelined RV32I core, sitting beside the pipeline registers and the PC. It detects data hazards and resolves them by forwarding or load-use stalls, including skipping x0. It handles redirects (branch/JAL/JALR) with a squash FSM that discards a fetch already in flight, and freezes the pipeline on instruction- and data-memory busy. It also keeps saturating stall and flush counters for performance measurement.

## Interface
- NSTAGE, 4: number of pipeline registers, index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB; minimum 3
- REG_AW, 5: register index width
- FWD_EN, 1: 1 = forwarding enabled; 0 = stall on every RAW match
- LOAD_FWD_STAGE, 3: first pipe register index from which load data can be forwarded
- REDIRECT_STAGE, 1: pipe register holding the resolving branch; registers 0..REDIRECT_STAGE are flushed on redirect
- DMEM_STAGE, 2: registers 0..DMEM_STAGE are frozen while DMEM_BUSY
- CNT_W, 16: width of the performance counters
- FSW = $clog2(NSTAGE): derived width of the forward selects

Ports:
- CLK  in  1  core clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ID_RS1, ID_RS2  in  REG_AW  source indices of the instruction in decode
- ID_RS1_USED, ID_RS2_USED  in  1  operand actually read
- ST_RD  in  NSTAGE*REG_AW  destination index held in each pipe register; slice k = [k*REG_AW +: REG_AW]
- ST_WE  in  NSTAGE  register-write valid per pipe register
- ST_LOAD  in  NSTAGE  instruction in that pipe register is a load
- REDIRECT  in  1  taken branch / JAL / JALR resolved in REDIRECT_STAGE
- IMEM_BUSY, IMEM_DONE  in  1  fetch outstanding; fetch completion pulse
- DMEM_BUSY  in  1  data access outstanding
- CNT_CLR  in  1  synchronous counter clear
- PIPE_EN  out  NSTAGE  per-register capture enable
- PIPE_FLUSH  out  NSTAGE  per-register bubble insert; overrides PIPE_EN
- PC_WRITE  out  1  PC update and new fetch permitted
- FWD_SEL1, FWD_SEL2  out  FSW  0 = register file; k = forward from pipe register k
- STALL_CNT, FLUSH_CNT  out  CNT_W  performance counters

## Operation
**Operand match.** For register k ≥ 1, an operand matches when all of these hold:
- the operand is used;
- rs ≠ 0;
- ST_WE[k] is set;
- ST_RD slice k equals rs.

**Youngest match.** The youngest match is the smallest such k.

**FWD_EN = 1.**
- If the youngest match is a load with k < LOAD_FWD_STAGE, the result is a load-use hazard.
- Otherwise FWD_SEL = k, or 0 if there is no match.

**FWD_EN = 0.**
- Any match is a hazard.
- FWD_SEL is held at 0.

**FSM states:** RUN and SQUASH (a redirect was taken while a wrong-path fetch is in flight).

**Default outputs:** PIPE_EN all 1, PIPE_FLUSH all 0, PC_WRITE 1.

**Per-cycle actions, first match wins:**
1. DMEM_BUSY:
   - PIPE_EN[0..DMEM_STAGE] = 0 and PC_WRITE = 0.
   - REDIRECT and hazards are ignored; the frozen REDIRECT re-presents next cycle.
   - In SQUASH, IMEM_DONE still asserts PIPE_FLUSH[0] and moves to RUN.
2. REDIRECT:
   - PIPE_FLUSH[0..REDIRECT_STAGE] = 1 and PC_WRITE = 1.
   - Next state is SQUASH if IMEM_BUSY, else RUN.
   - In SQUASH the state stays SQUASH even if IMEM_DONE is asserted the same cycle.
   - FLUSH_CNT increments.
3. SQUASH:
   - PC_WRITE = 0, PIPE_EN[0] = 0, PIPE_FLUSH[0] = 1.
   - IMEM_DONE moves to RUN.
4. IMEM_BUSY: PC_WRITE = 0, PIPE_EN[0] = 0, PIPE_FLUSH[1] = 1.
5. Data hazard: PC_WRITE = 0, PIPE_EN[0] = 0, PIPE_FLUSH[1] = 1.

**Counters.**
- STALL_CNT increments on every cycle with PC_WRITE = 0 outside reset.
- Both counters saturate at all-ones.
- CNT_CLR zeroes both and takes priority over increment.

## Timing
- All outputs except the counters are combinational from inputs and state, with zero-cycle latency.
- State and counters update on the rising edge of CLK.
- While RST is high:
  - PIPE_EN = 0, PIPE_FLUSH = all 1, PC_WRITE = 0, FWD_SEL = 0;
  - state = RUN, counters = 0.
- Asserting RST mid-SQUASH abandons the squash immediately.
- A load-use stall lasts LOAD_FWD_STAGE − k cycles; with defaults, a load in ID/EX costs 2 stall cycles.
- Worst-case SQUASH residency is unbounded; it ends on IMEM_DONE.

## Test plan
- Load-use: ST_LOAD[1] = 1, ST_WE[1] = 1, ST_RD[1] = 5, ID_RS1 = 5 used.
  - Expect PC_WRITE = 0, PIPE_EN[0] = 0, PIPE_FLUSH[1] = 1.
  - After the load reaches stage 3: FWD_SEL1 = 3 with no stall; STALL_CNT = 2.
- Forwarding priority: ALU writes x7 in stages 1 and 2, ID_RS2 = 7.
  - Expect FWD_SEL2 = 1 with no stall.
  - Same stimulus with ID_RS2 = 0: FWD_SEL2 = 0.
- FWD_EN = 0: ST_WE[3] = 1, ST_RD[3] = 9, ID_RS1 = 9.
  - Expect a stall with FWD_SEL1 = 0.
- Redirect during fetch: REDIRECT = 1 with IMEM_BUSY = 1.
  - Expect PIPE_FLUSH = 4'b0011, PC_WRITE = 1, then SQUASH.
  - For 3 cycles: PC_WRITE = 0 and PIPE_FLUSH[0] = 1.
  - IMEM_DONE returns to RUN; FLUSH_CNT = 1.
- DMEM freeze over redirect: DMEM_BUSY = 1 for 4 cycles with REDIRECT = 1.
  - Expect PIPE_EN = 4'b1000 and no flush.
  - On the cycle DMEM_BUSY drops, the flush occurs once.
- Reset mid-SQUASH and counter clear: assert RST for 2 cycles.
  - Expect all outputs at reset values and state RUN.
  - CNT_CLR concurrent with a stall gives STALL_CNT = 0.
  - Counter forced to 0xFFFF holds at 0xFFFF.
